// File: rtl/branch_resolution_unit.sv
// Branch resolution: turns the ID-stage taken/not-taken decision into SPARC delay-slot
// control (nPC redirect, delay-slot annul, DCTI-couple flag). Optional macro: BRANCH_STATS_EN.
module branch_resolution_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  ID_branch_instr,
    input  logic [3:0]            cond,
    input  logic                  annul_bit,
    input  logic                  branch_out,
    input  logic [ADDR_WIDTH-1:0] branch_target,
    output logic                  npc_sel,
    output logic [ADDR_WIDTH-1:0] npc_target,
    output logic                  squash_ds,
    output logic                  dcti_couple
`ifdef BRANCH_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0]  taken_count,
    output logic [CNT_WIDTH-1:0]  not_taken_count
`endif
);

    if (ADDR_WIDTH < 1 || CNT_WIDTH < 1) begin : g_param_check
        $error("branch_resolution_unit: widths must be positive");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        DSLOT = 1'b1
    } state_t;

    localparam logic [3:0] COND_BN = 4'b0000;
    localparam logic [3:0] COND_BA = 4'b1000;

    state_t                state_q, state_d;
    logic                  npc_sel_q, npc_sel_d;
    logic [ADDR_WIDTH-1:0] target_q, target_d;
    logic                  squash_q, squash_d;
    logic                  dcti_q, dcti_d;
    logic                  taken_w;
    logic                  squash_w;

    // bn never redirects; a taken branch only annuls its slot when it is ba,a.
    always_comb begin
        taken_w  = branch_out & (cond != COND_BN);
        squash_w = taken_w ? ((cond == COND_BA) & annul_bit) : annul_bit;
    end

    always_comb begin
        state_d   = state_q;
        npc_sel_d = npc_sel_q;
        target_d  = target_q;
        squash_d  = squash_q;
        dcti_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!stall && ID_branch_instr) begin
                    state_d   = DSLOT;
                    npc_sel_d = taken_w;
                    target_d  = branch_target;
                    squash_d  = squash_w;
                end
            end
            DSLOT: begin
                if (stall) begin
                    dcti_d = dcti_q;
                end else begin
                    // A branch in the delay slot is a DCTI couple unless that slot is annulled.
                    state_d   = IDLE;
                    npc_sel_d = 1'b0;
                    squash_d  = 1'b0;
                    dcti_d    = ID_branch_instr & ~squash_q;
                end
            end
            default: begin
                state_d   = IDLE;
                npc_sel_d = 1'b0;
                squash_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            npc_sel_q <= 1'b0;
            target_q  <= '0;
            squash_q  <= 1'b0;
            dcti_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            npc_sel_q <= npc_sel_d;
            target_q  <= target_d;
            squash_q  <= squash_d;
            dcti_q    <= dcti_d;
        end
    end

    assign npc_sel     = npc_sel_q;
    assign npc_target  = target_q;
    assign squash_ds   = squash_q;
    assign dcti_couple = dcti_q;

`ifdef BRANCH_STATS_EN
    logic [CNT_WIDTH-1:0] taken_cnt_q, taken_cnt_d;
    logic [CNT_WIDTH-1:0] nt_cnt_q, nt_cnt_d;
    logic                 capture_w;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_comb begin
        capture_w   = (state_q == IDLE) & ~stall & ID_branch_instr;
        taken_cnt_d = taken_cnt_q;
        nt_cnt_d    = nt_cnt_q;
        if (capture_w) begin
            if (taken_w) taken_cnt_d = sat_inc(taken_cnt_q);
            else         nt_cnt_d    = sat_inc(nt_cnt_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            taken_cnt_q <= '0;
            nt_cnt_q    <= '0;
        end else begin
            taken_cnt_q <= taken_cnt_d;
            nt_cnt_q    <= nt_cnt_d;
        end
    end

    assign taken_count     = taken_cnt_q;
    assign not_taken_count = nt_cnt_q;
`endif

endmodule

// File: tb/tb_branch_resolution_unit.sv
// Bench for branch_resolution_unit: directed delay-slot scenarios then random traffic
// checked against a transaction-level model of the delay-slot rules.
module tb_branch_resolution_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        ID_branch_instr = 1'b0;
    logic [3:0]  cond = 4'd0;
    logic        annul_bit = 1'b0;
    logic        branch_out = 1'b0;
    logic [31:0] branch_target = 32'd0;
    logic        npc_sel;
    logic [31:0] npc_target;
    logic        squash_ds;
    logic        dcti_couple;
`ifdef BRANCH_STATS_EN
    logic [15:0] taken_count;
    logic [15:0] not_taken_count;
`endif

    int tests = 0;
    int fails = 0;

    // Model: whether a delay slot is pending, and what that pending slot does.
    bit          m_in_slot;
    bit          m_redirect;
    bit          m_annul;
    bit          m_couple;
    logic [31:0] m_target;
    int          m_taken;
    int          m_not_taken;

    branch_resolution_unit #(.ADDR_WIDTH(32), .CNT_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .stall(stall), .ID_branch_instr(ID_branch_instr),
        .cond(cond), .annul_bit(annul_bit), .branch_out(branch_out),
        .branch_target(branch_target), .npc_sel(npc_sel), .npc_target(npc_target),
        .squash_ds(squash_ds), .dcti_couple(dcti_couple)
`ifdef BRANCH_STATS_EN
        , .taken_count(taken_count), .not_taken_count(not_taken_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock edge of the architectural rules, using the inputs presented at that edge.
    task automatic model_edge();
        bit is_taken;
        if (reset) begin
            m_in_slot = 0; m_redirect = 0; m_annul = 0; m_couple = 0; m_target = 0;
            m_taken = 0; m_not_taken = 0;
        end else if (stall) begin
            if (!m_in_slot) m_couple = 0;
        end else if (!m_in_slot) begin
            m_couple = 0;
            if (ID_branch_instr) begin
                is_taken   = branch_out && (cond != 4'd0);
                m_in_slot  = 1;
                m_redirect = is_taken;
                m_target   = branch_target;
                if (is_taken) m_annul = (cond == 4'd8) && annul_bit;
                else          m_annul = annul_bit;
                if (is_taken) m_taken = (m_taken < 65535) ? m_taken + 1 : m_taken;
                else          m_not_taken = (m_not_taken < 65535) ? m_not_taken + 1 : m_not_taken;
            end
        end else begin
            m_couple   = ID_branch_instr && !m_annul;
            m_in_slot  = 0;
            m_redirect = 0;
            m_annul    = 0;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".npc_sel"}, 64'(npc_sel), 64'(m_redirect));
        chk({tag, ".npc_target"}, 64'(npc_target), 64'(m_target));
        chk({tag, ".squash_ds"}, 64'(squash_ds), 64'(m_annul));
        chk({tag, ".dcti"}, 64'(dcti_couple), 64'(m_couple));
`ifdef BRANCH_STATS_EN
        chk({tag, ".taken_cnt"}, 64'(taken_count), 64'(m_taken));
        chk({tag, ".nt_cnt"}, 64'(not_taken_count), 64'(m_not_taken));
`endif
    endtask

    task automatic step(input bit rst, input bit stl, input bit br, input logic [3:0] cd,
                        input bit a, input bit bo, input logic [31:0] tgt, input string tag);
        @(negedge clk);
        reset = rst; stall = stl; ID_branch_instr = br; cond = cd;
        annul_bit = a; branch_out = bo; branch_target = tgt;
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic idle(input string tag);
        step(0, 0, 0, 4'd0, 0, 0, 32'hDEAD_BEEF, tag);
    endtask

    initial begin
        // Reset with random inputs
        for (int i = 0; i < 2; i++)
            step(1, 1'($urandom), 1'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
                 $urandom, "reset");
        chk("reset.npc_sel", 64'(npc_sel), 64'd0);
        chk("reset.npc_target", 64'(npc_target), 64'd0);
        chk("reset.squash", 64'(squash_ds), 64'd0);
        chk("reset.dcti", 64'(dcti_couple), 64'd0);

        // bne taken, a=0
        step(0, 0, 1, 4'b1001, 0, 1, 32'h0000_0040, "bne");
        chk("bne.npc_sel", 64'(npc_sel), 64'd1);
        chk("bne.target", 64'(npc_target), 64'h40);
        chk("bne.squash", 64'(squash_ds), 64'd0);
        idle("bne_exit");
        chk("bne_exit.npc_sel", 64'(npc_sel), 64'd0);
        chk("bne_exit.target_kept", 64'(npc_target), 64'h40);

        // be not taken, a=1; ba taken, a=1
        step(0, 0, 1, 4'b0001, 1, 0, 32'h100, "be_nt");
        chk("be_nt.npc_sel", 64'(npc_sel), 64'd0);
        chk("be_nt.squash", 64'(squash_ds), 64'd1);
        idle("be_exit");
        chk("be_exit.squash", 64'(squash_ds), 64'd0);
        step(0, 0, 1, 4'b1000, 1, 1, 32'h200, "ba_a");
        chk("ba_a.npc_sel", 64'(npc_sel), 64'd1);
        chk("ba_a.squash", 64'(squash_ds), 64'd1);
        idle("ba_exit");

        // bn, a=1: never redirects, slot annulled
        step(0, 0, 1, 4'b0000, 1, 1, 32'h300, "bn");
        chk("bn.npc_sel", 64'(npc_sel), 64'd0);
        chk("bn.squash", 64'(squash_ds), 64'd1);
        idle("bn_exit");

        // Taken bg with a=0, then branch in the delay slot
        step(0, 0, 1, 4'b1010, 0, 1, 32'h400, "bg");
        step(0, 0, 1, 4'b1000, 0, 1, 32'h500, "couple");
        chk("couple.dcti", 64'(dcti_couple), 64'd1);
        chk("couple.npc_sel", 64'(npc_sel), 64'd0);
        chk("couple.target", 64'(npc_target), 64'h400);
        idle("couple_end");
        chk("couple_end.dcti", 64'(dcti_couple), 64'd0);
        chk("couple_end.npc_sel", 64'(npc_sel), 64'd0);
        // ba,a annuls the slot: no couple
        step(0, 0, 1, 4'b1000, 1, 1, 32'h600, "ba_a2");
        step(0, 0, 1, 4'b1001, 0, 1, 32'h700, "annulled_couple");
        chk("annulled_couple.dcti", 64'(dcti_couple), 64'd0);
        chk("annulled_couple.target", 64'(npc_target), 64'h600);
        idle("ac_end");

        // Stall 3 cycles in DSLOT
        step(0, 0, 1, 4'b1001, 0, 1, 32'h800, "stall_br");
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 1'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), $urandom, "stalled");
            chk("stalled.npc_sel", 64'(npc_sel), 64'd1);
            chk("stalled.target", 64'(npc_target), 64'h800);
        end
        idle("stall_exit");
        chk("stall_exit.npc_sel", 64'(npc_sel), 64'd0);

        // Reset in DSLOT
        step(0, 0, 1, 4'b1000, 1, 1, 32'h900, "pre_rst");
        step(1, 0, 1, 4'b1000, 1, 1, 32'h900, "rst_dslot");
        chk("rst_dslot.npc_sel", 64'(npc_sel), 64'd0);
        chk("rst_dslot.squash", 64'(squash_ds), 64'd0);
        chk("rst_dslot.target", 64'(npc_target), 64'd0);

        // 3 taken + 2 not-taken after reset
        step(0, 0, 1, 4'b1000, 0, 1, 32'h10, "s1"); idle("s1x");
        step(0, 0, 1, 4'b0001, 0, 0, 32'h20, "s2"); idle("s2x");
        step(0, 0, 1, 4'b1001, 0, 1, 32'h30, "s3"); idle("s3x");
        step(0, 0, 1, 4'b0000, 0, 1, 32'h40, "s4"); idle("s4x");
        step(0, 0, 1, 4'b1010, 1, 1, 32'h50, "s5"); idle("s5x");
`ifdef BRANCH_STATS_EN
        chk("stats.taken", 64'(taken_count), 64'd3);
        chk("stats.not_taken", 64'(not_taken_count), 64'd2);
`endif

        // Random traffic
        for (int i = 0; i < 400; i++)
            step(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) == 0), 1'($urandom),
                 4'($urandom), 1'($urandom), 1'($urandom), $urandom, "rand");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
